// File: rtl/iscbdiv_pkg.sv
// Shared width helpers and lane state layout for the iscbdiv_nch stochastic divider.
package iscbdiv_pkg;

  function automatic int unsigned cnt_width(input int unsigned sync_depth);
    return $clog2(sync_depth + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned buf_depth);
    return (buf_depth > 1) ? $clog2(buf_depth) : 1;
  endfunction

  localparam int unsigned DefSyncDepth = 4;
  localparam int unsigned DefBufDepth  = 4;
  localparam int unsigned DefCntW      = cnt_width(DefSyncDepth);

  // Lane state at the default depths; each lane re-declares this shape at its own widths.
  typedef struct packed {
    logic [DefCntW-1:0]     cnt;
    logic                   sdiv;
    logic                   sdvr;
    logic [DefBufDepth-1:0] hist;
  } lane_state_t;

endpackage

// File: rtl/iscbdiv_lane.sv
// One divider lane: skewed synchroniser feeding a correlation divider with history replay.
// Optional sticky overflow flag under ISCBDIV_OVF_FLAG_EN.
module iscbdiv_lane
  import iscbdiv_pkg::*;
#(
  parameter int unsigned SYNC_DEPTH = 4,
  parameter int unsigned BUF_DEPTH  = 4,
  parameter logic        BUF_INIT   = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic [idx_width(BUF_DEPTH)-1:0]   rand_num_i,
  input  logic                              dividend_i,
  input  logic                              divisor_i,
`ifdef ISCBDIV_OVF_FLAG_EN
  output logic                              sync_ovf_o,
`endif
  output logic                              quotient_o
);

  localparam int unsigned CntW = cnt_width(SYNC_DEPTH);
  localparam logic [CntW-1:0] CntMax = CntW'(SYNC_DEPTH);

  typedef struct packed {
    logic [CntW-1:0]      cnt;
    logic                 sdiv;
    logic                 sdvr;
    logic [BUF_DEPTH-1:0] hist;
  } state_t;

  localparam state_t StReset = '{
    cnt:  '0,
    sdiv: 1'b0,
    sdvr: 1'b0,
    hist: {BUF_DEPTH{BUF_INIT}}
  };

  state_t st_q, st_d;
  logic   quot_q, quot_d;

  always_comb begin
    st_d   = st_q;
    quot_d = quot_q;
    if (en_i) begin
      st_d.sdvr = divisor_i;
      st_d.sdiv = 1'b0;
      unique case ({dividend_i, divisor_i})
        2'b11: st_d.sdiv = 1'b1;
        // Unmatched dividend 1 is banked; once full, the excess is dropped.
        2'b10: if (st_q.cnt != CntMax) st_d.cnt = st_q.cnt + CntW'(1);
        2'b01: begin
          if (st_q.cnt != '0) begin
            st_d.sdiv = 1'b1;
            st_d.cnt  = st_q.cnt - CntW'(1);
          end
        end
        default: ;
      endcase

      if (st_q.sdvr) begin
        quot_d    = st_q.sdiv;
        st_d.hist = {st_q.hist[BUF_DEPTH-2:0], st_q.sdiv};
      end else begin
        quot_d = st_q.hist[rand_num_i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q   <= StReset;
      quot_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      quot_q <= quot_d;
    end
  end

  assign quotient_o = quot_q;

`ifdef ISCBDIV_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (en_i && dividend_i && !divisor_i && (st_q.cnt == CntMax)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign sync_ovf_o = ovf_q;
`endif

endmodule

// File: rtl/iscbdiv_nch.sv
// NCH-lane in-stream correlation-based stochastic divider; only en, randNum and reset are shared.
// Define ISCBDIV_OVF_FLAG_EN to add the per-lane sticky sync_ovf output.
module iscbdiv_nch
  import iscbdiv_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned SYNC_DEPTH = 4,
  parameter int unsigned BUF_DEPTH  = 4,
  parameter logic        BUF_INIT   = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [idx_width(BUF_DEPTH)-1:0] randNum,
  input  logic [NCH-1:0]                  dividend,
  input  logic [NCH-1:0]                  divisor,
`ifdef ISCBDIV_OVF_FLAG_EN
  output logic [NCH-1:0]                  sync_ovf,
`endif
  output logic [NCH-1:0]                  quotient
);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    iscbdiv_lane #(
      .SYNC_DEPTH (SYNC_DEPTH),
      .BUF_DEPTH  (BUF_DEPTH),
      .BUF_INIT   (BUF_INIT)
    ) u_lane (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (en),
      .rand_num_i (randNum),
      .dividend_i (dividend[i]),
      .divisor_i  (divisor[i]),
`ifdef ISCBDIV_OVF_FLAG_EN
      .sync_ovf_o (sync_ovf[i]),
`endif
      .quotient_o (quotient[i])
    );
  end

endmodule
